// File: rtl/hazard_pkg.sv
// Shared encodings for the EX hazard controller: forwarding selects and FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_BRFLUSH = 2'd2,
        ST_MEMWAIT = 2'd3
    } state_t;

    localparam logic [1:0] FWD_RF        = 2'd0;
    localparam logic [1:0] FWD_EXMEM_ALU = 2'd1;
    localparam logic [1:0] FWD_MEMWB_ALU = 2'd2;
    localparam logic [1:0] FWD_MEMWB_LD  = 2'd3;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding priority: youngest producer wins (EX ALU, then MEM ALU, then MEM load).
module fwd_select
    import hazard_pkg::*;
(
    input  logic [2:0] i_src,
    input  logic       i_used,
    input  logic       i_p2_alu_wr,
    input  logic [2:0] i_p2_alu_rd,
    input  logic       i_p3_alu_wr,
    input  logic [2:0] i_p3_alu_rd,
    input  logic       i_p3_ld_wr,
    input  logic [2:0] i_p3_mem_rd,
    output logic [1:0] o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (!i_used)
            o_sel = FWD_RF;
        else if (i_p2_alu_wr && (i_p2_alu_rd == i_src))
            o_sel = FWD_EXMEM_ALU;
        else if (i_p3_alu_wr && (i_p3_alu_rd == i_src))
            o_sel = FWD_MEMWB_ALU;
        else if (i_p3_ld_wr && (i_p3_mem_rd == i_src))
            o_sel = FWD_MEMWB_LD;
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: registered forwarding selects, load-use stall,
// branch flush sequencing and memory-wait freeze for a dual-issue ALU/MEM pipe.
//
//   state      | meaning
//   RUN        | normal flow; load-use stall is raised combinationally here
//   LDSTALL    | one cycle after a load-use stall (bubble now in EX)
//   BRFLUSH    | remaining flush cycles after a taken branch, r_cnt = cycles left
//   MEMWAIT    | pipeline frozen by mem_busy; r_resume holds interrupted state
module ex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [2:0] id_alu_rn,
    input  logic [2:0] id_alu_rm,
    input  logic [2:0] id_mem_rn,
    input  logic [2:0] id_mem_rd,
    input  logic       id_alu_rm_used,
    input  logic       id_mem_rd_used,
    input  logic       p2_alu_regWrite,
    input  logic       p2_mem_regWrite,
    input  logic       p2_memRead,
    input  logic [2:0] p2_alu_rd,
    input  logic [2:0] p2_mem_rd,
    input  logic       p3_alu_regWrite,
    input  logic       p3_mem_regWrite,
    input  logic       p3_memRead,
    input  logic [2:0] p3_alu_rd,
    input  logic [2:0] p3_mem_rd,
    input  logic       branch_taken,
    input  logic       mem_busy,
    output logic [1:0] f_alu_reg_rn_sel,
    output logic [1:0] f_alu_reg_rm_sel,
    output logic [1:0] f_mem_reg_rn_sel,
    output logic       f_mem_reg_rd_sel,
    output logic       pc_write,
    output logic       p1_regWrite,
    output logic       p2_regWrite,
    output logic       p3_pipeline_regWrite,
    output logic       ID_flush,
    output logic       EX_flush,
    output logic       busy
);

    // The branch cycle itself is the first flush cycle, so BRFLUSH owes one fewer.
    localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t     r_state;
    state_t     r_resume;
    logic [1:0] r_cnt;
    logic [1:0] r_rn_sel, r_rm_sel, r_mrn_sel;
    logic       r_mrd_sel;

    state_t     w_eff;
    state_t     w_state_nxt;
    state_t     w_resume_nxt;
    logic [1:0] w_cnt_nxt;
    logic [1:0] w_rn_sel, w_rm_sel, w_mrn_sel, w_mrd_sel;
    logic       w_p3_ld;
    logic       w_load_use;

    assign w_p3_ld = p3_memRead & p3_mem_regWrite;

    fwd_select u_fwd_alu_rn (
        .i_src(id_alu_rn), .i_used(1'b1),
        .i_p2_alu_wr(p2_alu_regWrite), .i_p2_alu_rd(p2_alu_rd),
        .i_p3_alu_wr(p3_alu_regWrite), .i_p3_alu_rd(p3_alu_rd),
        .i_p3_ld_wr(w_p3_ld), .i_p3_mem_rd(p3_mem_rd),
        .o_sel(w_rn_sel)
    );

    fwd_select u_fwd_alu_rm (
        .i_src(id_alu_rm), .i_used(1'b1),
        .i_p2_alu_wr(p2_alu_regWrite), .i_p2_alu_rd(p2_alu_rd),
        .i_p3_alu_wr(p3_alu_regWrite), .i_p3_alu_rd(p3_alu_rd),
        .i_p3_ld_wr(w_p3_ld), .i_p3_mem_rd(p3_mem_rd),
        .o_sel(w_rm_sel)
    );

    fwd_select u_fwd_mem_rn (
        .i_src(id_mem_rn), .i_used(1'b1),
        .i_p2_alu_wr(p2_alu_regWrite), .i_p2_alu_rd(p2_alu_rd),
        .i_p3_alu_wr(p3_alu_regWrite), .i_p3_alu_rd(p3_alu_rd),
        .i_p3_ld_wr(w_p3_ld), .i_p3_mem_rd(p3_mem_rd),
        .o_sel(w_mrn_sel)
    );

    // Store data only has an EX/MEM bypass; the other priorities are ignored.
    fwd_select u_fwd_mem_rd (
        .i_src(id_mem_rd), .i_used(id_mem_rd_used),
        .i_p2_alu_wr(p2_alu_regWrite), .i_p2_alu_rd(p2_alu_rd),
        .i_p3_alu_wr(p3_alu_regWrite), .i_p3_alu_rd(p3_alu_rd),
        .i_p3_ld_wr(w_p3_ld), .i_p3_mem_rd(p3_mem_rd),
        .o_sel(w_mrd_sel)
    );

    assign w_load_use = id_valid & p2_memRead & p2_mem_regWrite &
                        ((p2_mem_rd == id_alu_rn) ||
                         (id_alu_rm_used && (p2_mem_rd == id_alu_rm)) ||
                         (p2_mem_rd == id_mem_rn) ||
                         (id_mem_rd_used && (p2_mem_rd == id_mem_rd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_resume <= ST_RUN;
            r_cnt    <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_resume <= w_resume_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Leaving MEMWAIT acts as the resumed state in the same cycle, so no dead cycle.
    always_comb begin
        w_eff                = (r_state == ST_MEMWAIT) ? r_resume : r_state;
        w_state_nxt          = w_eff;
        w_resume_nxt         = r_resume;
        w_cnt_nxt            = r_cnt;
        pc_write             = 1'b1;
        p1_regWrite          = 1'b1;
        p2_regWrite          = 1'b1;
        p3_pipeline_regWrite = 1'b1;
        ID_flush             = 1'b0;
        EX_flush             = 1'b0;
        if (mem_busy) begin
            pc_write             = 1'b0;
            p1_regWrite          = 1'b0;
            p2_regWrite          = 1'b0;
            p3_pipeline_regWrite = 1'b0;
            w_state_nxt          = ST_MEMWAIT;
            w_resume_nxt         = w_eff;
        end else if (branch_taken) begin
            ID_flush    = 1'b1;
            EX_flush    = 1'b1;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = (FLUSH_CYCLES > 1) ? ST_BRFLUSH : ST_RUN;
        end else begin
            case (w_eff)
                ST_RUN: begin
                    if (w_load_use) begin
                        pc_write    = 1'b0;
                        p1_regWrite = 1'b0;
                        ID_flush    = 1'b1;
                        w_state_nxt = ST_LDSTALL;
                    end
                end
                ST_LDSTALL: w_state_nxt = ST_RUN;
                ST_BRFLUSH: begin
                    ID_flush = 1'b1;
                    EX_flush = 1'b1;
                    if (r_cnt <= 2'd1) begin
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rn_sel  <= FWD_RF;
            r_rm_sel  <= FWD_RF;
            r_mrn_sel <= FWD_RF;
            r_mrd_sel <= 1'b0;
        end else if (p2_regWrite) begin
            if (ID_flush) begin
                r_rn_sel  <= FWD_RF;
                r_rm_sel  <= FWD_RF;
                r_mrn_sel <= FWD_RF;
                r_mrd_sel <= 1'b0;
            end else begin
                r_rn_sel  <= w_rn_sel;
                r_rm_sel  <= w_rm_sel;
                r_mrn_sel <= w_mrn_sel;
                r_mrd_sel <= (w_mrd_sel == FWD_EXMEM_ALU);
            end
        end
    end

    assign f_alu_reg_rn_sel = r_rn_sel;
    assign f_alu_reg_rm_sel = r_rm_sel;
    assign f_mem_reg_rn_sel = r_mrn_sel;
    assign f_mem_reg_rd_sel = r_mrd_sel;
    assign busy             = (r_state != ST_RUN);

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed hazard scenarios, then random traffic,
// all checked every cycle against a cycle-level behavioural model.
module tb_ex_hazard_ctrl;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [2:0] id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd;
    logic       id_alu_rm_used, id_mem_rd_used;
    logic       p2_alu_regWrite, p2_mem_regWrite, p2_memRead;
    logic [2:0] p2_alu_rd, p2_mem_rd;
    logic       p3_alu_regWrite, p3_mem_regWrite, p3_memRead;
    logic [2:0] p3_alu_rd, p3_mem_rd;
    logic       branch_taken, mem_busy;
    logic [1:0] f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel;
    logic       f_mem_reg_rd_sel;
    logic       pc_write, p1_regWrite, p2_regWrite, p3_pipeline_regWrite;
    logic       ID_flush, EX_flush, busy;

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_alu_rn(id_alu_rn), .id_alu_rm(id_alu_rm),
        .id_mem_rn(id_mem_rn), .id_mem_rd(id_mem_rd),
        .id_alu_rm_used(id_alu_rm_used), .id_mem_rd_used(id_mem_rd_used),
        .p2_alu_regWrite(p2_alu_regWrite), .p2_mem_regWrite(p2_mem_regWrite),
        .p2_memRead(p2_memRead), .p2_alu_rd(p2_alu_rd), .p2_mem_rd(p2_mem_rd),
        .p3_alu_regWrite(p3_alu_regWrite), .p3_mem_regWrite(p3_mem_regWrite),
        .p3_memRead(p3_memRead), .p3_alu_rd(p3_alu_rd), .p3_mem_rd(p3_mem_rd),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .f_alu_reg_rn_sel(f_alu_reg_rn_sel), .f_alu_reg_rm_sel(f_alu_reg_rm_sel),
        .f_mem_reg_rn_sel(f_mem_reg_rn_sel), .f_mem_reg_rd_sel(f_mem_reg_rd_sel),
        .pc_write(pc_write), .p1_regWrite(p1_regWrite), .p2_regWrite(p2_regWrite),
        .p3_pipeline_regWrite(p3_pipeline_regWrite),
        .ID_flush(ID_flush), .EX_flush(EX_flush), .busy(busy)
    );

    int total  = 0;
    int passed = 0;
    bit chk_en = 0;

    // Model: flush cycles still owed, "just stalled" flag, "was waiting" flag, registered selects.
    int         m_owed;
    bit         m_ldsh, m_wait;
    logic [1:0] m_rn, m_rm, m_mrn;
    logic       m_mrd;
    logic [3:0] e_en;
    logic [1:0] e_fl;
    logic       e_busy;
    bit         e_lu;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] youngest(input logic [2:0] src);
        if (p2_alu_regWrite && p2_alu_rd == src) return 2'd1;
        if (p3_alu_regWrite && p3_alu_rd == src) return 2'd2;
        if (p3_memRead && p3_mem_regWrite && p3_mem_rd == src) return 2'd3;
        return 2'd0;
    endfunction

    function automatic bit reads_reg(input logic [2:0] r);
        return (id_alu_rn == r) || (id_alu_rm_used && id_alu_rm == r) ||
               (id_mem_rn == r) || (id_mem_rd_used && id_mem_rd == r);
    endfunction

    task automatic compute_exp();
        e_en   = 4'hF;
        e_fl   = 2'b00;
        e_lu   = 0;
        e_busy = m_wait || (m_owed > 0) || m_ldsh;
        if (mem_busy) e_en = 4'h0;
        else if (branch_taken || m_owed > 0) e_fl = 2'b11;
        else if (!m_ldsh && id_valid && p2_memRead && p2_mem_regWrite && reads_reg(p2_mem_rd)) begin
            e_lu = 1;
            e_en = 4'b0011;
            e_fl = 2'b10;
        end
    endtask

    task automatic update_model();
        if (reset) begin
            m_owed = 0; m_ldsh = 0; m_wait = 0;
            m_rn = 0; m_rm = 0; m_mrn = 0; m_mrd = 0;
            return;
        end
        if (e_en[1]) begin
            if (e_fl[1]) begin
                m_rn = 0; m_rm = 0; m_mrn = 0; m_mrd = 0;
            end else begin
                m_rn  = youngest(id_alu_rn);
                m_rm  = youngest(id_alu_rm);
                m_mrn = youngest(id_mem_rn);
                m_mrd = id_mem_rd_used && p2_alu_regWrite && (p2_alu_rd == id_mem_rd);
            end
        end
        if (mem_busy) begin
            m_wait = 1;
        end else begin
            m_wait = 0;
            if (branch_taken) begin
                m_owed = FC - 1;
                m_ldsh = 0;
            end else if (m_owed > 0) m_owed--;
            else if (m_ldsh) m_ldsh = 0;
            else if (e_lu) m_ldsh = 1;
        end
    endtask

    task automatic tick();
        #3;
        compute_exp();
        if (chk_en) begin
            chk("enables", {pc_write, p1_regWrite, p2_regWrite, p3_pipeline_regWrite}, e_en);
            chk("flushes", {ID_flush, EX_flush}, e_fl);
            chk("busy", busy, e_busy);
            chk("selects", {f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel},
                {m_rn, m_rm, m_mrn, m_mrd});
        end
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic clear_in();
        reset = 0; id_valid = 1;
        id_alu_rn = 3'd7; id_alu_rm = 3'd6; id_mem_rn = 3'd5; id_mem_rd = 3'd4;
        id_alu_rm_used = 0; id_mem_rd_used = 0;
        p2_alu_regWrite = 0; p2_mem_regWrite = 0; p2_memRead = 0; p2_alu_rd = 0; p2_mem_rd = 0;
        p3_alu_regWrite = 0; p3_mem_regWrite = 0; p3_memRead = 0; p3_alu_rd = 0; p3_mem_rd = 0;
        branch_taken = 0; mem_busy = 0;
    endtask

    initial begin
        clear_in();
        reset = 1;
        #1;
        tick(); tick();
        chk_en = 1;
        reset = 0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_en", {pc_write, p1_regWrite, p2_regWrite, p3_pipeline_regWrite}, 4'hF);
        chk("rst_sel", {f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel}, 7'd0);
        tick();

        // EX ALU writes r3, ID reads alu_rn=r3
        p2_alu_regWrite = 1; p2_alu_rd = 3'd3; id_alu_rn = 3'd3;
        tick();
        clear_in();
        chk("fwd_rn_ex", f_alu_reg_rn_sel, 2'd1);
        tick();

        // youngest producer wins over an older load to the same register
        p2_alu_regWrite = 1; p2_alu_rd = 3'd5;
        p3_memRead = 1; p3_mem_regWrite = 1; p3_mem_rd = 3'd5;
        id_alu_rm = 3'd5; id_alu_rm_used = 1; id_alu_rn = 3'd0; id_mem_rn = 3'd1;
        tick();
        clear_in();
        chk("fwd_rm_young", f_alu_reg_rm_sel, 2'd1);
        tick();

        // load-use on mem_rn=r2, then load data forwarded from MEM/WB
        p2_memRead = 1; p2_mem_regWrite = 1; p2_mem_rd = 3'd2; id_mem_rn = 3'd2;
        #1;
        chk("ldu_pc", pc_write, 1'b0);
        chk("ldu_idf", ID_flush, 1'b1);
        tick();
        clear_in();
        id_mem_rn = 3'd2; p3_memRead = 1; p3_mem_regWrite = 1; p3_mem_rd = 3'd2;
        #1;
        chk("ldu_busy", busy, 1'b1);
        chk("ldu_pc_back", pc_write, 1'b1);
        tick();
        clear_in();
        chk("ldu_fwd", f_mem_reg_rn_sel, 2'd3);
        tick();

        // single branch: exactly FC flush cycles
        for (int c = 0; c < FC + 1; c++) begin
            branch_taken = (c == 0);
            #1;
            chk("br_flush", {ID_flush, EX_flush}, (c < FC) ? 2'b11 : 2'b00);
            tick();
        end
        chk("br_done", busy, 1'b0);

        // mem_busy for 3 cycles in the second flush cycle, then remaining flush
        branch_taken = 1;
        tick();
        branch_taken = 0;
        for (int c = 0; c < 3; c++) begin
            mem_busy = 1;
            #1;
            chk("mw_en", {pc_write, p1_regWrite, p2_regWrite, p3_pipeline_regWrite, ID_flush, EX_flush}, 6'd0);
            tick();
        end
        mem_busy = 0;
        #1;
        chk("mw_resume", {ID_flush, EX_flush}, 2'b11);
        tick();
        #1;
        chk("mw_after", {ID_flush, EX_flush, busy}, 3'b000);
        tick();

        // reset during LDSTALL abandons it
        p2_memRead = 1; p2_mem_regWrite = 1; p2_mem_rd = 3'd1; id_alu_rn = 3'd1;
        tick();
        clear_in();
        reset = 1; p2_alu_regWrite = 1; p2_alu_rd = 3'd7;
        tick();
        clear_in();
        #1;
        chk("rst_ld_en", {pc_write, p1_regWrite, p2_regWrite, p3_pipeline_regWrite, ID_flush}, 5'b11110);
        chk("rst_ld_sel", {f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel}, 7'd0);
        chk("rst_ld_busy", busy, 1'b0);
        tick();

        for (int i = 0; i < 2000; i++) begin
            reset           = ($urandom_range(0, 79) == 0);
            mem_busy        = ($urandom_range(0, 5) == 0);
            branch_taken    = ($urandom_range(0, 9) == 0);
            id_valid        = ($urandom_range(0, 7) != 0);
            id_alu_rn       = 3'($urandom_range(0, 3));
            id_alu_rm       = 3'($urandom_range(0, 3));
            id_mem_rn       = 3'($urandom_range(0, 3));
            id_mem_rd       = 3'($urandom_range(0, 3));
            id_alu_rm_used  = 1'($urandom_range(0, 1));
            id_mem_rd_used  = 1'($urandom_range(0, 1));
            p2_alu_regWrite = 1'($urandom_range(0, 1));
            p2_mem_regWrite = 1'($urandom_range(0, 1));
            p2_memRead      = 1'($urandom_range(0, 1));
            p2_alu_rd       = 3'($urandom_range(0, 3));
            p2_mem_rd       = 3'($urandom_range(0, 3));
            p3_alu_regWrite = 1'($urandom_range(0, 1));
            p3_mem_regWrite = 1'($urandom_range(0, 1));
            p3_memRead      = 1'($urandom_range(0, 1));
            p3_alu_rd       = 3'($urandom_range(0, 3));
            p3_mem_rd       = 3'($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles ID_flush/EX_flush stay high after a taken branch (legal 1..3).
REQ-002 SHALL have ports in this order, clock and reset first:
 clk  in  1  single clock; all state updates on rising edge.
 reset  in  1  synchronous, active-high reset.
 id_valid  in  1  instruction bundle in ID is real (not a bubble).
 id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd  in  3 each  source registers of the ID bundle.
 id_alu_rm_used, id_mem_rd_used  in  1 each  rm read (not immediate); store data read.
 p2_alu_regWrite, p2_mem_regWrite, p2_memRead  in  1 each  controls of the bundle in EX.
 p2_alu_rd, p2_mem_rd  in  3 each  destinations of the bundle in EX.
 p3_alu_regWrite, p3_mem_regWrite, p3_memRead  in  1 each  controls of the bundle in MEM.
 p3_alu_rd, p3_mem_rd  in  3 each  destinations of the bundle in MEM.
 branch_taken  in  1  taken branch/jump resolved this cycle.
 mem_busy  in  1  data memory cannot complete this cycle.
 f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel  out  2 each  registered EX forwarding selects.
 f_mem_reg_rd_sel  out  1  registered EX store-data forwarding select.
 pc_write, p1_regWrite  out  1 each  PC and IF/ID register enables.
 p2_regWrite, p3_pipeline_regWrite  out  1 each  ID/EX and EX/MEM register enables.
 ID_flush, EX_flush  out  1 each  bubble insertion into ID/EX and EX/MEM.
 busy  out  1  state is not RUN.

Function
REQ-003 SHALL encode 2-bit selects: 0 register file, 1 EX/MEM ALU result, 2 MEM/WB ALU result, 3 MEM/WB load data.
REQ-004 SHALL compute next select per ID operand by priority: p2 ALU write match -> 1; else p3 ALU write match -> 2; else p3 load (p3_memRead and p3_mem_regWrite) match -> 3; else 0.
REQ-005 SHALL set f_mem_reg_rd_sel next value 1 only on p2 ALU write match to id_mem_rd with id_mem_rd_used, else 0.
REQ-006 SHALL register selects only when p2_regWrite is high; SHALL load zeros when ID/EX receives a bubble (stall or flush).
REQ-007 SHALL detect load-use when id_valid and p2_memRead and p2_mem_regWrite and p2_mem_rd equals any used ID source.
REQ-008 SHALL implement FSM states RUN, LDSTALL, BRFLUSH, MEMWAIT.
REQ-009 RUN: load-use -> LDSTALL for exactly 1 cycle; pc_write=p1_regWrite=0, ID_flush=1 that cycle; return to RUN.
REQ-010 Any state: branch_taken (and not mem_busy) -> ID_flush=EX_flush=1 same cycle, enter BRFLUSH, hold both flushes for FLUSH_CYCLES total cycles via counter, then RUN.
REQ-011 mem_busy in any state -> MEMWAIT: all four enables 0, no flushes, counter and selects frozen; on mem_busy low, resume the interrupted state with its counter value.
REQ-012 Priority per cycle: reset > mem_busy > branch_taken > load-use; branch_taken during BRFLUSH restarts the counter.
REQ-013 In RUN with no hazard: all enables 1, flushes 0.
REQ-014 busy SHALL be high in LDSTALL, BRFLUSH, MEMWAIT.

Reset
REQ-015 On reset: state RUN, counter 0, all selects 0, flushes 0, all enables 1, busy 0, effective the next rising edge.
REQ-016 Reset asserted mid-stall/flush/wait SHALL abandon it with no residual flush cycle.

Structure
REQ-017 SHALL place select encodings (FWD_RF, FWD_EXMEM_ALU, FWD_MEMWB_ALU, FWD_MEMWB_LD) and FSM state encoding in shared package hazard_pkg.
REQ-018 SHALL use one sub-module fwd_select (combinational per-operand priority comparator), instantiated four times.

Verification
REQ-019 p2 ALU writes r3, ID reads alu_rn=r3 -> next cycle f_alu_reg_rn_sel=1.
REQ-020 p2 ALU writes r5 and p3 load writes r5, ID rm=r5 -> next f_alu_reg_rm_sel=1 (youngest wins).
REQ-021 p2 load to r2, ID mem_rn=r2 -> 1 cycle pc_write=0, ID_flush=1; following cycle f_mem_reg_rn_sel=3.
REQ-022 branch_taken one cycle, FLUSH_CYCLES=2 -> ID_flush=EX_flush=1 for exactly 2 cycles, then RUN.
REQ-023 mem_busy high 3 cycles during BRFLUSH cycle 1 -> enables 0 for 3 cycles, then 1 remaining flush cycle.
REQ-024 reset asserted in LDSTALL -> next cycle all enables 1, selects 0, busy 0.
